conv_row_display: RTL



---
 rtl/conv_row_display.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/conv_row_display.sv
// conv_row_display: buffers one ROWS x COLS binary result frame and plays it out one row at a time.
// Latency: a frame handshake at edge N shows row 0 after N; a step first sampled high at edge N moves the row at N+2.
// Backpressure: frame_ready is low for the whole playout, so a frame offered while SHOW is simply not taken.
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   frame_data   : ROWS*COLS result frame, row r = frame_data[r*COLS +: COLS]
//   frame_valid  : frame_data valid; frame_ready: block can accept a frame (IDLE)
//   step         : asynchronous advance request (pushbutton/switch), rising edge advances
//   row_out      : displayed row (zero when idle); row_valid: row_out holds frame data
//   row_idx      : index of the displayed row; last_row: row_idx == ROWS-1 while row_valid
//   frame_done   : one-cycle pulse after the last row is retired
//
// Build option AUTO_SCROLL_EN: rows advance every SCROLL_DIV cycles from an internal
// counter and step is ignored. Without it, rows advance only on step rising edges.
module conv_row_display #(
    parameter int ROWS       = 6,
    parameter int COLS       = 6,
    parameter int SCROLL_DIV = 1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ROWS*COLS-1:0] frame_data,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    input  logic                 step,
    output logic [COLS-1:0]      row_out,
    output logic                 row_valid,
    output logic [2:0]           row_idx,
    output logic                 last_row,
    output logic                 frame_done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SHOW = 1'b1
    } state_e;

    localparam logic [2:0] LAST_IDX = 3'(ROWS - 1);

    state_e          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic            done_q, done_d;
    logic [COLS-1:0] buf_q [ROWS];
    logic            capture;
    logic            advance;

    assign capture = (state_q == S_IDLE) && frame_valid;

`ifdef AUTO_SCROLL_EN
    // Free-running row timer: restarts on capture and on every advance, so each
    // row is visible for exactly SCROLL_DIV cycles.
    localparam int               CNT_W   = $clog2(SCROLL_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCROLL_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             unused_step;

    assign unused_step = step;
    assign advance     = (state_q == S_SHOW) && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = '0;
        if ((state_q == S_SHOW) && !advance) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // step is asynchronous: two flops to resynchronise, a third to find the
    // rising edge. prev follows sync2 in every state, so an edge seen while
    // idle is consumed there and cannot fire once the next frame starts.
    localparam int unused_div = SCROLL_DIV;

    logic sync1_q, sync2_q, prev_q;

    assign advance = sync2_q && !prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= step;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (frame_valid) begin
                    state_d = S_SHOW;
                    idx_d   = 3'd0;
                end
            end
            S_SHOW: begin
                if (advance) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                        idx_d   = 3'd0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    // Frame buffer: loaded only on the accepting edge, so later frame_data
    // activity cannot reach the display.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                buf_q[r] <= '0;
            end
        end else if (capture) begin
            for (int r = 0; r < ROWS; r++) begin
                buf_q[r] <= frame_data[r*COLS +: COLS];
            end
        end
    end

    // Outputs, decoded from registered state only
    always_comb begin
        frame_ready = 1'b1;
        row_valid   = 1'b0;
        row_out     = '0;
        row_idx     = idx_q;
        last_row    = 1'b0;
        if (state_q == S_SHOW) begin
            frame_ready = 1'b0;
            row_valid   = 1'b1;
            row_out     = buf_q[idx_q];
            last_row    = (idx_q == LAST_IDX);
        end
    end

    assign frame_done = done_q;

endmodule
